// File: rtl/tmds_pkg.sv
// tmds_pkg: shared definitions for the TMDS/HDMI link encoder.
//   mode_e       - period-type encoding as carried on the mode input
//   CTRL_xx      - control-period symbols, indexed by {c1,c0}
//   VGB_*/DGB_*  - guard-band symbols
//   terc4()      - 4-bit to 10-bit TERC4 mapping for data islands
//   popcnt8()    - ones count of a byte
//   decode_mode()- folds the unused mode values 5-7 onto CTRL
package tmds_pkg;

   typedef enum logic [2:0] {
      MODE_CTRL  = 3'd0,
      MODE_VIDEO = 3'd1,
      MODE_VGB   = 3'd2,
      MODE_DATA  = 3'd3,
      MODE_DGB   = 3'd4
   } mode_e;

   localparam logic [9:0] CTRL_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_11 = 10'b1010101011;

   localparam logic [9:0] VGB_RB  = 10'b1011001100;  // roles 0 and 2
   localparam logic [9:0] VGB_G   = 10'b0100110011;  // role 1
   localparam logic [9:0] DGB_GR  = 10'b0100110011;  // roles 1 and 2

   function automatic logic [9:0] terc4(input logic [3:0] d);
      logic [9:0] s;
      s = 10'b1010011100;
      case (d)
         4'h0: s = 10'b1010011100;
         4'h1: s = 10'b1001100011;
         4'h2: s = 10'b1011100100;
         4'h3: s = 10'b1011100010;
         4'h4: s = 10'b0101110001;
         4'h5: s = 10'b0100011110;
         4'h6: s = 10'b0110001110;
         4'h7: s = 10'b0100111100;
         4'h8: s = 10'b1011001100;
         4'h9: s = 10'b0100111001;
         4'hA: s = 10'b0110011100;
         4'hB: s = 10'b1011000111;
         4'hC: s = 10'b1010001110;
         4'hD: s = 10'b1001110001;
         4'hE: s = 10'b0101100011;
         4'hF: s = 10'b1011000011;
      endcase
      return s;
   endfunction

   function automatic logic [3:0] popcnt8(input logic [7:0] d);
      logic [3:0] n;
      n = '0;
      for (int unsigned i = 0; i < 8; i++) n = n + {3'b000, d[i]};
      return n;
   endfunction

   function automatic mode_e decode_mode(input logic [2:0] m);
      mode_e r;
      case (m)
         3'd1:    r = MODE_VIDEO;
         3'd2:    r = MODE_VGB;
         3'd3:    r = MODE_DATA;
         3'd4:    r = MODE_DGB;
         default: r = MODE_CTRL;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tmds_lane_enc.sv
// tmds_lane_enc: one TMDS lane, two pipeline stages.
//   Stage 1 registers the period type, the transition-minimised q_m[8:0]
//   and its ones count, plus the control/aux bits for non-video periods.
//   Stage 2 selects the output symbol and maintains the running disparity.
// Ports:
//   i_clk, i_rst (async, active high), i_ce (advance enable)
//   i_mode  period type (already folded to mode_e)
//   i_vd    video byte, i_cd control bits, i_aux TERC4 nibble
//   o_tmds  10-bit symbol, bit 0 first on the wire
module tmds_lane_enc
   import tmds_pkg::*;
#(
   parameter int unsigned ROLE  = 0,
   parameter int unsigned CNT_W = 5
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_ce,
   input  mode_e      i_mode,
   input  logic [7:0] i_vd,
   input  logic [1:0] i_cd,
   input  logic [3:0] i_aux,
   output logic [9:0] o_tmds
);

   localparam logic signed [CNT_W-1:0] C_TWO   = CNT_W'(2);
   localparam logic signed [CNT_W-1:0] C_EIGHT = CNT_W'(8);

   function automatic logic [8:0] qm_encode(input logic [7:0] d);
      logic [8:0] q;
      logic [3:0] n;
      logic       use_xnor;
      n        = popcnt8(d);
      use_xnor = (n > 4'd4) || (n == 4'd4 && !d[0]);
      q        = '0;
      q[0]     = d[0];
      for (int unsigned k = 1; k < 8; k++)
         q[k] = use_xnor ? ~(q[k-1] ^ d[k]) : (q[k-1] ^ d[k]);
      q[8] = ~use_xnor;
      return q;
   endfunction

   // stage 1
   mode_e       r_mode;
   logic [8:0]  r_qm;
   logic [3:0]  r_n1;
   logic [1:0]  r_cd;
   logic [3:0]  r_aux;
   logic [8:0]  w_qm;

   assign w_qm = qm_encode(i_vd);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mode <= MODE_CTRL;
         r_qm   <= '0;
         r_n1   <= '0;
         r_cd   <= '0;
         r_aux  <= '0;
      end else if (i_ce) begin
         r_mode <= i_mode;
         r_qm   <= w_qm;
         r_n1   <= popcnt8(w_qm[7:0]);
         r_cd   <= i_cd;
         r_aux  <= i_aux;
      end
   end

   // stage 2
   logic [9:0]              r_tmds;
   logic signed [CNT_W-1:0] r_cnt;
   logic signed [CNT_W-1:0] w_diff;      // N1 - N0 of q_m[7:0]
   logic signed [CNT_W-1:0] w_cnt_nx;
   logic [9:0]              w_sym;

   always_comb begin
      w_diff   = ($signed({{(CNT_W-4){1'b0}}, r_n1}) <<< 1) - C_EIGHT;
      w_sym    = CTRL_00;
      w_cnt_nx = '0;
      case (r_mode)
         MODE_VIDEO: begin
            if (r_cnt == '0 || r_n1 == 4'd4) begin
               w_sym    = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
               w_cnt_nx = r_qm[8] ? r_cnt + w_diff : r_cnt - w_diff;
            // cnt is non-zero here, so its sign bit alone decides cnt>0 / cnt<0
            end else if ((!r_cnt[CNT_W-1] && r_n1 > 4'd4) ||
                         ( r_cnt[CNT_W-1] && r_n1 < 4'd4)) begin
               w_sym    = {1'b1, r_qm[8], ~r_qm[7:0]};
               w_cnt_nx = r_cnt - w_diff + (r_qm[8] ? C_TWO : '0);
            end else begin
               w_sym    = {1'b0, r_qm[8], r_qm[7:0]};
               w_cnt_nx = r_cnt + w_diff - (r_qm[8] ? '0 : C_TWO);
            end
         end
         MODE_VGB:  w_sym = (ROLE == 1) ? VGB_G : VGB_RB;
         MODE_DATA: w_sym = (ROLE == 0) ? terc4({r_aux[3:2], r_cd}) : terc4(r_aux);
         MODE_DGB:  w_sym = (ROLE == 0) ? terc4({2'b11, r_cd}) : DGB_GR;
         default: begin
            case (r_cd)
               2'b00: w_sym = CTRL_00;
               2'b01: w_sym = CTRL_01;
               2'b10: w_sym = CTRL_10;
               2'b11: w_sym = CTRL_11;
            endcase
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tmds <= CTRL_00;
         r_cnt  <= '0;
      end else if (i_ce) begin
         r_tmds <= w_sym;
         r_cnt  <= w_cnt_nx;
      end
   end

   assign o_tmds = r_tmds;

endmodule

// File: rtl/tmds_link_encoder.sv
// tmds_link_encoder: NUM_CH-lane TMDS/HDMI symbol encoder with a fixed
// two-stage pipeline and clock enable. Lane i takes role i mod 3
// (0 blue/sync, 1 green, 2 red).
// Ports:
//   clk, rst (async, active high), ce (pipeline advance)
//   mode       period type: 0 CTRL, 1 VIDEO, 2 VGB, 3 DATA, 4 DGB, 5-7 CTRL
//   vd/cd/aux  per-lane video byte, control pair, TERC4 nibble
//   tmds       per-lane 10-bit symbols, lane i at [10i+9:10i]
//   valid_out  set once two ce-qualified inputs have entered since reset
module tmds_link_encoder
   import tmds_pkg::*;
#(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned CNT_W  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic [2:0]            mode,
   input  logic [8*NUM_CH-1:0]   vd,
   input  logic [2*NUM_CH-1:0]   cd,
   input  logic [4*NUM_CH-1:0]   aux,
   output logic [10*NUM_CH-1:0]  tmds,
   output logic                  valid_out
);

   mode_e      w_mode;
   logic [1:0] r_vld;

   assign w_mode = decode_mode(mode);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     r_vld <= '0;
      else if (ce) r_vld <= {r_vld[0], 1'b1};
   end

   assign valid_out = r_vld[1];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      tmds_lane_enc #(
         .ROLE  (i % 3),
         .CNT_W (CNT_W)
      ) u_lane (
         .i_clk  (clk),
         .i_rst  (rst),
         .i_ce   (ce),
         .i_mode (w_mode),
         .i_vd   (vd[8*i +: 8]),
         .i_cd   (cd[2*i +: 2]),
         .i_aux  (aux[4*i +: 4]),
         .o_tmds (tmds[10*i +: 10])
      );
   end

endmodule

// File: tb/tb_tmds_link_encoder.sv
module tb_tmds_link_encoder;

   localparam int unsigned NC = 6;
   localparam logic [9:0]  K_RST = 10'h354;
   localparam logic [9:0]  T4 [16] = '{
      10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
      10'h2CC, 10'h139, 10'h19C, 10'h2C7, 10'h28E, 10'h271, 10'h163, 10'h2C3};

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 ce;
   logic [2:0]           mode;
   logic [8*NC-1:0]      vd;
   logic [2*NC-1:0]      cd;
   logic [4*NC-1:0]      aux;
   logic [10*NC-1:0]     tmds;
   logic                 valid_out;

   always #5 clk = ~clk;

   tmds_link_encoder #(.NUM_CH(NC), .CNT_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .mode      (mode),
      .vd        (vd),
      .cd        (cd),
      .aux       (aux),
      .tmds      (tmds),
      .valid_out (valid_out)
   );

   typedef struct {
      logic [10*NC-1:0] tm;
      int unsigned      due;
      string            tag;
   } exp_t;

   exp_t             q[$];
   int               mcnt [NC];
   int unsigned      edge_n;
   logic [10*NC-1:0] cur_exp;
   int               n_chk = 0;
   int               n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] model(input int ln, input logic [2:0] m, input logic [7:0] d,
                                        input logic [1:0] c, input logic [3:0] a);
      int         role;
      int         n1d;
      int         n1;
      int         n0;
      logic       use_xnor;
      logic [8:0] qm;
      logic [9:0] sym;
      role = ln % 3;
      sym  = K_RST;
      if (m != 3'd1) mcnt[ln] = 0;
      case (m)
         3'd1: begin
            n1d = 0;
            for (int i = 0; i < 8; i++) n1d += int'(d[i]);
            use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
            qm[0] = d[0];
            for (int k = 1; k < 8; k++) qm[k] = use_xnor ? ~(qm[k-1] ^ d[k]) : (qm[k-1] ^ d[k]);
            qm[8] = !use_xnor;
            n1 = 0;
            for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
            n0 = 8 - n1;
            if (mcnt[ln] == 0 || n1 == n0) begin
               sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
               mcnt[ln] += qm[8] ? (n1 - n0) : (n0 - n1);
            end else if ((mcnt[ln] > 0 && n1 > n0) || (mcnt[ln] < 0 && n0 > n1)) begin
               sym = {1'b1, qm[8], ~qm[7:0]};
               mcnt[ln] += 2 * int'(qm[8]) + n0 - n1;
            end else begin
               sym = {1'b0, qm[8], qm[7:0]};
               mcnt[ln] += n1 - n0 - (qm[8] ? 0 : 2);
            end
         end
         3'd2: sym = (role == 1) ? 10'h133 : 10'h2CC;
         3'd3: sym = (role == 0) ? T4[{a[3:2], c}] : T4[a];
         3'd4: sym = (role == 0) ? T4[{2'b11, c}] : 10'h133;
         default: begin
            case (c)
               2'b00: sym = 10'h354;
               2'b01: sym = 10'h0AB;
               2'b10: sym = 10'h154;
               2'b11: sym = 10'h2AB;
            endcase
         end
      endcase
      return sym;
   endfunction

   task automatic step(input logic c);
      ce = c;
      @(posedge clk);
      #1;
      if (c) edge_n++;
      while (q.size() > 0 && q[0].due == edge_n) begin
         exp_t e;
         e = q.pop_front();
         check(e.tag, 64'(tmds), 64'(e.tm));
         cur_exp = e.tm;
      end
      if (!c) check("hold", 64'(tmds), 64'(cur_exp));
      check("valid", 64'(valid_out), 64'(edge_n >= 2));
   endtask

   task automatic push(input string tag, input logic [2:0] m, input logic [8*NC-1:0] d,
                       input logic [2*NC-1:0] c, input logic [4*NC-1:0] a);
      exp_t e;
      mode = m;
      vd   = d;
      cd   = c;
      aux  = a;
      for (int ln = 0; ln < NC; ln++)
         e.tm[10*ln +: 10] = model(ln, m, d[8*ln +: 8], c[2*ln +: 2], a[4*ln +: 4]);
      e.due = edge_n + 2;
      e.tag = tag;
      q.push_back(e);
      step(1'b1);
   endtask

   task automatic rand_inputs();
      for (int ln = 0; ln < NC; ln++) begin
         vd[8*ln +: 8]  = 8'($urandom);
         cd[2*ln +: 2]  = 2'($urandom);
         aux[4*ln +: 4] = 4'($urandom);
      end
      mode = 3'($urandom);
   endtask

   task automatic push_rand(input string tag);
      logic [8*NC-1:0] d;
      logic [2*NC-1:0] c;
      logic [4*NC-1:0] a;
      logic [2:0]      m;
      for (int ln = 0; ln < NC; ln++) begin
         d[8*ln +: 8] = 8'($urandom);
         c[2*ln +: 2] = 2'($urandom);
         a[4*ln +: 4] = 4'($urandom);
      end
      m = ($urandom_range(0, 9) < 7) ? 3'd1 : 3'($urandom);
      push(tag, m, d, c, a);
   endtask

   task automatic clear_model();
      q.delete();
      for (int ln = 0; ln < NC; ln++) mcnt[ln] = 0;
      edge_n  = 0;
      cur_exp = {NC{K_RST}};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   initial begin
      logic [7:0] dir_v [6];
      dir_v = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0};
      rst  = 1'b1;
      ce   = 1'b0;
      mode = 3'd0;
      vd   = '0;
      cd   = '0;
      aux  = '0;
      clear_model();
      #12;
      check("reset_tmds", 64'(tmds), 64'({NC{K_RST}}));
      check("reset_valid", 64'(valid_out), 64'(1'b0));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // ce low straight after reset: nothing advances
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         step(1'b0);
      end

      push("ctrl00", 3'd0, '0, {NC{2'b00}}, '0);
      push("ctrl01", 3'd0, '0, {NC{2'b01}}, '0);
      push("ctrl10", 3'd0, '0, {NC{2'b10}}, '0);
      push("ctrl11", 3'd0, '0, {NC{2'b11}}, '0);

      push("vid00_a", 3'd1, '0, '0, '0);
      push("vid00_b", 3'd1, '0, '0, '0);
      push("vid00_c", 3'd1, '0, '0, '0);
      push("ctrl_gap", 3'd0, '0, '0, '0);
      push("vid00_restart", 3'd1, '0, '0, '0);

      push("vgb", 3'd2, '0, {NC{2'b10}}, '0);
      push("dgb", 3'd4, '0, {NC{2'b10}}, '0);
      push("data5", 3'd3, '0, {NC{2'b01}}, {NC{4'h5}});
      push("flush_a", 3'd0, '0, '0, '0);
      push("mode7", 3'd7, '0, {NC{2'b11}}, '0);

      // freeze with junk on the inputs
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         step(1'b0);
      end
      push("after_hold", 3'd0, '0, '0, '0);

      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 3; j++)
            push("vid_dir", 3'd1, {NC{dir_v[i]}}, '0, '0);
      end

      for (int i = 0; i < 40; i++) push_rand("rand");

      // asynchronous reset in the middle of a cycle
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_tmds", 64'(tmds), 64'({NC{K_RST}}));
      check("midrst_valid", 64'(valid_out), 64'(1'b0));
      clear_model();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 12; i++) push_rand("post_rst");
      push("flush_b", 3'd0, '0, '0, '0);
      push("flush_c", 3'd0, '0, '0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tmds_link_encoder.md
Name: tmds_link_encoder

Overview:
- Multi-channel TMDS/HDMI symbol encoder; successor to the fixed 3-channel DVI-only encoder.
- Covers all HDMI 1.x period types: control, video data, video guard band, data island (TERC4) and data-island guard band.
- Parametrised channel count for multi-link designs; adds a clock-enable and a fixed 2-stage pipeline.
- Sits between the video timing/packet scheduler and the per-lane 10:1 serializers.

Parameters:
- NUM_CH, 3, number of TMDS data lanes; must be a multiple of 3. Lane i takes role i mod 3: role 0 = blue/sync, 1 = green, 2 = red.
- CNT_W, 5, width of the signed running-disparity counter per lane; minimum 5.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- ce  in  1  pipeline advance enable; when low, all registers hold
- mode  in  3  period type: 0 CTRL, 1 VIDEO, 2 VGB (video guard band), 3 DATA (TERC4), 4 DGB (data guard band); values 5-7 are treated as CTRL
- vd  in  8*NUM_CH  video bytes, lane i at [8i+7:8i]
- cd  in  2*NUM_CH  control bits per lane; role-0 lanes carry {vsync,hsync}
- aux  in  4*NUM_CH  TERC4 nibbles per lane
- tmds  out  10*NUM_CH  encoded symbols, lane i at [10i+9:10i]; bit 0 is transmitted first
- valid_out  out  1  high once the pipeline holds two ce-qualified inputs since reset

Behaviour:
- Reset (async): tmds = all lanes 10'b1101010100 (CTRL code for 00); valid_out = 0; all disparity counters = 0; pipeline mode registers = CTRL.
- Latency: exactly 2 ce-qualified cycles from input sample to tmds. Stage 1 registers mode, per-lane q_m[8:0] and N1(q_m[7:0]). Stage 2 produces tmds and updates disparity.
- ce low: no register changes, tmds and disparity are held, and ce is not sampled into valid_out.
- Stage-1 video (q_m) rule:
  - Use XNOR when N1(D) > 4, or when N1(D) == 4 and D[0] == 0; otherwise use XOR.
  - q_m[0] = D[0]; q_m[k] = q_m[k-1] xor/xnor D[k].
  - q_m[8] = 1 for XOR, 0 for XNOR.
- Stage-2 VIDEO, per lane. N1/N0 count the ones/zeros of q_m[7:0]; cnt is signed CNT_W bits.
  - Case A, cnt == 0 or N1 == N0:
    - out = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m8 ? (N1 - N0) : (N0 - N1).
  - Case B, (cnt > 0 and N1 > N0) or (cnt < 0 and N0 > N1):
    - out = {1, q_m8, ~q_m[7:0]}.
    - cnt += 2*q_m8 + (N0 - N1).
  - Case C, otherwise:
    - out = {0, q_m8, q_m[7:0]}.
    - cnt += (N1 - N0) - 2*(~q_m8).
- Non-VIDEO modes: disparity counter is cleared to 0 on every ce cycle. Codes are written tmds[9:0], MSB first.
  - CTRL:
    - cd 00 -> 1101010100
    - cd 01 -> 0010101011
    - cd 10 -> 0101010100
    - cd 11 -> 1010101011
  - VGB:
    - role 0 and role 2 -> 1011001100
    - role 1 -> 0100110011
  - DATA, per TERC4 nibble:
    - role 0 encodes {aux[3:2], cd[1:0]}; roles 1 and 2 encode aux[3:0].
    - 0->1010011100, 1->1001100011, 2->1011100100, 3->1011100010
    - 4->0101110001, 5->0100011110, 6->0110001110, 7->0100111100
    - 8->1011001100, 9->0100111001, A->0110011100, B->1011000111
    - C->1010001110, D->1001110001, E->0101100011, F->1011000011
  - DGB:
    - role 0 -> TERC4 of {1, 1, cd[1:0]}
    - roles 1 and 2 -> 0100110011
- Mode switch into VIDEO: the first video symbol starts from cnt = 0.
- Mode switch mid-stream: takes effect in the cycle it reaches stage 2; there is no blending.
- Disparity counter: must never overflow for CNT_W >= 5 (range ±10 is reachable). Arithmetic is done sign-extended in CNT_W bits.
- Reset asserted mid-stream: immediate return to reset values. The first post-reset symbol appears 2 ce cycles after deassertion.

Decomposition:
- Package tmds_pkg holds:
  - mode encodings
  - the four CTRL codes
  - both guard-band codes
  - the TERC4 16-entry table as a function
  - the popcount function
- One sub-module, tmds_lane_enc: a single lane with stage 1 and stage 2 plus its disparity counter, parametrised by ROLE and CNT_W.
- Top level generates NUM_CH instances and the valid_out shift register.

Test Plan:
- Reset, then mode CTRL with cd = 00..11 on lane 0 -> tmds lane 0 = 354h, 0ABh, 154h, 2ABh, each 2 cycles after input.
- VIDEO, vd = 00h on three consecutive cycles -> lane outputs 100h, 3FFh, 100h; internal cnt = -8, +2, -6.
- VIDEO stream -> CTRL for 1 cycle -> VIDEO 00h again -> output 100h (cnt restarted at 0).
- VGB then DGB with cd = 10b, NUM_CH = 3 -> VGB 2CCh/133h/2CCh; DGB lane 0 = TERC4(Eh) = 163h, lanes 1 and 2 = 133h.
- DATA, aux = 5h on all lanes, cd = 2'b01, aux[3:2] = 01 -> lane 0 = TERC4(5h) = 11Eh, lanes 1 and 2 = 11Eh. Hold ce low 3 cycles -> tmds frozen, valid_out unchanged.
- NUM_CH = 6 random VIDEO vectors checked against a reference model; assert rst mid-stream -> tmds = 354h immediately and valid_out = 0.
